booth_mul_ctrl: RTL and testbench

BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

---
 rtl/booth_mul_ctrl.sv | 106 ++++++++++
 tb/tb_booth_mul_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth sequential signed multiplier: one CALC/SHIFT pair per multiplier bit.
// busy/done are registered from the next state, so they never depend on start combinationally.
module booth_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_calc;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shift;
  logic             q_1;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_dec;

  // Booth add/subtract (modulo 2^(WIDTH+1)) and the arithmetic shift of {acc,q,q_1}
  always_comb begin
    cnt_dec = cnt - CW'(1);
    case ({q[0], q_1})
      2'b10:   acc_calc = acc - m;
      2'b01:   acc_calc = acc + m;
      default: acc_calc = acc;
    endcase
    acc_shift = {acc[WIDTH], acc[WIDTH:1]};
    q_shift   = {acc[0], q[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  state_next = S_SHIFT;
      S_SHIFT: state_next = (cnt_dec == '0) ? S_DONE : S_CALC;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_CALC) || (state_next == S_SHIFT);
      done  <= (state_next == S_DONE);
    end
  end

  // Operand capture, iteration datapath, and result load on the final shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m   <= {a[WIDTH-1], a};
            acc <= '0;
            q   <= b;
            q_1 <= 1'b0;
            cnt <= CW'(WIDTH);
          end
        end
        S_CALC: acc <= acc_calc;
        S_SHIFT: begin
          acc <= acc_shift;
          q   <= q_shift;
          q_1 <= q[0];
          cnt <= cnt_dec;
          if (cnt_dec == '0) product <= {acc_shift[WIDTH-1:0], q_shift};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed and random checks for booth_mul_ctrl at WIDTH=8.
module tb_booth_mul_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks;
  int n_err;
  int done_cnt;
  int overlap_cnt;
  int n_start;

  booth_mul_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands and raise start
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
  endtask

  // Accepting edge is the next posedge; returns at the negedge where done is high
  task automatic wait_done(input logic [2*W-1:0] exp, input bit hold, input string tag);
    int idx;
    int busy_n;
    bit seen;
    @(posedge clk);
    idx = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && idx < 40) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        a = W'($urandom);
        b = W'($urandom);
        idx++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(idx), 32'(2 * W));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(2 * W));
    check({tag, " product"}, 32'(product), 32'(exp));
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[2*W-1:0];
  endfunction

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    n_checks = 0; n_err = 0; done_cnt = 0; overlap_cnt = 0; n_start = 0;
    vecs[0] = '{8'h03, 8'h04, 16'h000C};
    vecs[1] = '{8'hFD, 8'h04, 16'hFFF4};
    vecs[2] = '{8'h05, 8'hF9, 16'hFFDD};
    vecs[3] = '{8'h80, 8'h80, 16'h4000};
    vecs[4] = '{8'h80, 8'h7F, 16'hC080};
    vecs[5] = '{8'h00, 8'hFF, 16'h0000};

    start = 1'b0; a = '0; b = '0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].x, vecs[i].y);
      wait_done(vecs[i].p, 1'b0, $sformatf("dir%0d", i));
      n_start++;
      @(negedge clk);
      check($sformatf("dir%0d pulse_width", i), 32'(done), 32'd0);
      check($sformatf("dir%0d product_hold", i), 32'(product), 32'(vecs[i].p));
    end

    // Idle with start low leaves product untouched
    a = 8'h11; b = 8'h22;
    repeat (5) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle product", 32'(product), 32'h0000);

    // start held high: DONE ignores it, IDLE accepts on the following edge
    start_op(8'h07, 8'hFE);
    wait_done(16'hFFF2, 1'b1, "hold1");
    n_start++;
    a = 8'd9; b = 8'd11;
    @(negedge clk);
    check("hold idle busy", 32'(busy), 32'd0);
    check("hold idle done", 32'(done), 32'd0);
    wait_done(16'h0063, 1'b0, "hold2");
    n_start++;
    @(negedge clk);

    // Asynchronous reset mid-operation
    start_op(8'h05, 8'h06);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst product", 32'(product), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst hold busy", 32'(busy), 32'd0);
    check("midrst hold product", 32'(product), 32'd0);
    start_op(8'h03, 8'h04);
    rst_n = 1'b1;
    wait_done(16'h000C, 1'b0, "post_rst");
    n_start++;

    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = W'($urandom);
      @(negedge clk);
      start_op(x, y);
      wait_done(ref_mul(x, y), 1'b0, "rand");
      n_start++;
    end
    @(negedge clk);
    @(negedge clk);

    check("done_count", 32'(done_cnt), 32'(n_start));
    check("busy_done_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
